// File: rtl/seq_driver.sv
// seq_driver: run controller for a bit-serial sequence detector.
// Captures a pattern, clears the detector for one cycle, streams the
// pattern LSB-first into x_out, and counts/locates hits on f_in.
module seq_driver #(
   parameter int WIDTH = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             start,
   input  logic [WIDTH-1:0] pattern,
   input  logic [4:0]       len,
   input  logic             f_in,
   output logic             x_out,
   output logic             m_rst_n,
   output logic             busy,
   output logic             done,
   output logic [4:0]       f_count,
   output logic [4:0]       first_hit,
   output logic             hit_valid
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam logic [4:0] WMAX = 5'(WIDTH);

   state_t           state;
   logic [WIDTH-1:0] pat_r;
   logic [4:0]       len_r;
   logic [4:0]       k;
   logic [4:0]       len_eff;
   logic [4:0]       idx;
   logic             sample;

   // Clamp requested length and decide whether f_in is sampled this cycle,
   // and which already-consumed bit the sample is attributed to.
   always_comb begin
      len_eff = (len > WMAX) ? WMAX : len;
      sample  = 1'b0;
      idx     = '0;
      if (state == S_RUN && k != 5'd0) begin
         sample = 1'b1;
         idx    = k - 5'd1;
      end else if (state == S_DRAIN) begin
         sample = 1'b1;
         idx    = len_r - 5'd1;
      end
   end

   // Run FSM with registered outputs and hit bookkeeping.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state     <= S_IDLE;
         pat_r     <= '0;
         len_r     <= '0;
         k         <= '0;
         x_out     <= 1'b0;
         m_rst_n   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         f_count   <= '0;
         first_hit <= '0;
         hit_valid <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               x_out   <= 1'b0;
               m_rst_n <= 1'b1;
               busy    <= 1'b0;
               done    <= 1'b0;
               if (start) begin
                  pat_r <= pattern;
                  len_r <= len_eff;
                  if (len_eff == 5'd0) begin
                     f_count   <= '0;
                     hit_valid <= 1'b0;
                     done      <= 1'b1;
                     state     <= S_DONE;
                  end else begin
                     f_count   <= '0;
                     first_hit <= '0;
                     hit_valid <= 1'b0;
                     m_rst_n   <= 1'b0;
                     busy      <= 1'b1;
                     state     <= S_CLEAR;
                  end
               end
            end
            S_CLEAR: begin
               // Pattern register is consumed as a shift register so the
               // next bit to send is always at bit 0.
               m_rst_n <= 1'b1;
               x_out   <= pat_r[0];
               pat_r   <= pat_r >> 1;
               k       <= '0;
               state   <= S_RUN;
            end
            S_RUN: begin
               if (k == len_r - 5'd1) begin
                  x_out <= 1'b0;
                  state <= S_DRAIN;
               end else begin
                  x_out <= pat_r[0];
                  pat_r <= pat_r >> 1;
                  k     <= k + 5'd1;
               end
            end
            S_DRAIN: begin
               x_out <= 1'b0;
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= S_DONE;
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase

         if (sample && f_in) begin
            f_count <= f_count + 5'd1;
            if (!hit_valid) begin
               first_hit <= idx;
               hit_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_seq_driver.sv
// Self-checking bench for seq_driver: a cycle-offset model of each run plus
// directed runs with hand-computed expectations.
module tb_seq_driver;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        start;
   logic [15:0] pattern;
   logic [4:0]  len;
   logic        f_in;
   logic        x_out;
   logic        m_rst_n;
   logic        busy;
   logic        done;
   logic [4:0]  f_count;
   logic [4:0]  first_hit;
   logic        hit_valid;

   int checks = 0;
   int passes = 0;

   seq_driver #(.WIDTH(16)) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .start     (start),
      .pattern   (pattern),
      .len       (len),
      .f_in      (f_in),
      .x_out     (x_out),
      .m_rst_n   (m_rst_n),
      .busy      (busy),
      .done      (done),
      .f_count   (f_count),
      .first_hit (first_hit),
      .hit_valid (hit_valid)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Model: mc is the cycle offset since the accepting edge (0 = idle).
   // Offset 1 clear, 2..L+1 send bit mc-2, L+2 drain, L+3 done.
   int          mc;
   int          mL;
   logic [15:0] mpat;
   int          mcnt;
   int          mfirst;
   logic        mhv;
   logic        mmr;

   always @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         mc = 0; mL = 0; mpat = '0; mcnt = 0; mfirst = 0; mhv = 1'b0; mmr = 1'b0;
      end else if (mc == 0) begin
         mmr = 1'b1;
         if (start) begin
            mpat = pattern;
            mL   = (len > 16) ? 16 : int'(len);
            mcnt = 0;
            mhv  = 1'b0;
            if (mL == 0) mc = 3;
            else begin
               mfirst = 0;
               mc     = 1;
            end
         end
      end else begin
         // Offset mc samples the detector after bit mc-3.
         if (mc >= 3 && mc <= mL + 2 && f_in) begin
            mcnt++;
            if (!mhv) begin
               mfirst = mc - 3;
               mhv    = 1'b1;
            end
         end
         mc = (mc == mL + 3) ? 0 : mc + 1;
      end
   end

   // Compare every output against the model shortly after each edge.
   always @(posedge CLK) begin
      int ex, em, eb, ed;
      #1;
      if (RESET) begin
         ex = 0; em = 1; eb = 0; ed = 0;
         if (mc == 0) em = int'(mmr);
         else if (mc == 1) begin em = 0; eb = 1; end
         else if (mc <= mL + 1) begin ex = int'(mpat[mc-2]); eb = 1; end
         else if (mc == mL + 2) eb = 1;
         else ed = 1;
         chk("x_out",     int'(x_out),     ex);
         chk("m_rst_n",   int'(m_rst_n),   em);
         chk("busy",      int'(busy),      eb);
         chk("done",      int'(done),      ed);
         chk("f_count",   int'(f_count),   mcnt);
         chk("first_hit", int'(first_hit), mfirst);
         chk("hit_valid", int'(hit_valid), int'(mhv));
      end
   end

   logic xs [0:31];
   logic ms [0:31];
   int   done_c;
   int   done_n;
   int   busy_n;
   int   mlow_n;

   task automatic check_reset_vals(input string tag);
      chk({tag, "_x"},  int'(x_out),     0);
      chk({tag, "_m"},  int'(m_rst_n),   0);
      chk({tag, "_b"},  int'(busy),      0);
      chk({tag, "_d"},  int'(done),      0);
      chk({tag, "_fc"}, int'(f_count),   0);
      chk({tag, "_fh"}, int'(first_hit), 0);
      chk({tag, "_hv"}, int'(hit_valid), 0);
   endtask

   // One run: fm[c] is f_in during cycle c; rs_c re-pulses start, rst_c pulls reset.
   task automatic run(input logic [15:0] p, input logic [4:0] l, input logic [31:0] fm,
                      input int rs_c, input int rst_c);
      done_c = -1; done_n = 0; busy_n = 0; mlow_n = 0;
      @(negedge CLK);
      pattern = p; len = l; start = 1'b1; f_in = fm[0];
      @(posedge CLK); #1;
      for (int c = 1; c <= 26; c++) begin
         xs[c] = x_out;
         ms[c] = m_rst_n;
         if (busy) busy_n++;
         if (!m_rst_n) mlow_n++;
         if (done) begin
            done_n++;
            if (done_c < 0) done_c = c;
         end
         @(negedge CLK);
         start   = (c == rs_c);
         pattern = ~p;
         len     = l ^ 5'h1F;
         f_in    = fm[c];
         if (c == rst_c) begin
            RESET = 1'b0;
            #1;
            check_reset_vals("midrun_rst");
         end
         if (rst_c > 0 && c == rst_c + 2) RESET = 1'b1;
         @(posedge CLK); #1;
      end
      f_in = 1'b0;
      start = 1'b0;
   endtask

   initial begin
      RESET = 1'b0; start = 1'b0; pattern = '0; len = '0; f_in = 1'b0;
      #2;
      check_reset_vals("por");
      repeat (2) @(negedge CLK);
      RESET = 1'b1;
      repeat (2) @(negedge CLK);

      // len 4, pattern 1011, no hits
      run(16'h000B, 5'd4, 32'h0, 0, 0);
      chk("t1_xseq", int'({xs[5], xs[4], xs[3], xs[2]}), 4'b1011);
      chk("t1_m1", int'(ms[1]), 0);
      chk("t1_mlow", mlow_n, 1);
      chk("t1_done_c", done_c, 7);
      chk("t1_fc", int'(f_count), 0);
      chk("t1_hv", int'(hit_valid), 0);

      // len 4, f_in always high
      run(16'h0005, 5'd4, 32'hFFFF_FFFF, 0, 0);
      chk("t2_fc", int'(f_count), 4);
      chk("t2_fh", int'(first_hit), 0);
      chk("t2_hv", int'(hit_valid), 1);
      chk("t2_done_c", done_c, 7);

      // len 6, f_in high in cycles 5 and 8 (8 is the drain sample)
      run(16'h002D, 5'd6, 32'h0000_0120, 0, 0);
      chk("t3_fc", int'(f_count), 2);
      chk("t3_fh", int'(first_hit), 2);
      chk("t3_done_c", done_c, 9);

      // len 0: immediate done, never busy
      run(16'hFFFF, 5'd0, 32'hFFFF_FFFF, 0, 0);
      chk("t4_done_c", done_c, 1);
      chk("t4_busy_n", busy_n, 0);
      chk("t4_fc", int'(f_count), 0);
      chk("t4_hv", int'(hit_valid), 0);

      // len 20 clamps to 16
      run(16'hA5C3, 5'd20, 32'h0, 0, 0);
      chk("t5_done_c", done_c, 19);
      chk("t5_busy_n", busy_n, 18);

      // len 8 with a second start in cycle 3
      run(16'h00C9, 5'd8, 32'h0000_0010, 3, 0);
      chk("t6_done_c", done_c, 11);
      chk("t6_done_n", done_n, 1);
      chk("t6_fc", int'(f_count), 1);
      chk("t6_fh", int'(first_hit), 1);

      // len 8 with reset in cycle 4, then a fresh run
      run(16'h00FF, 5'd8, 32'hFFFF_FFFF, 0, 4);
      chk("t7_done_n", done_n, 0);
      chk("t7_fc", int'(f_count), 0);
      run(16'h0005, 5'd3, 32'hFFFF_FFFF, 0, 0);
      chk("t7b_done_c", done_c, 6);
      chk("t7b_fc", int'(f_count), 3);
      chk("t7b_fh", int'(first_hit), 0);
      chk("t7b_hv", int'(hit_valid), 1);

      repeat (3) @(negedge CLK);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
